// File: rtl/mmio_console_pkg.sv
// ==================================================================
// mmio_console_pkg : MMIO addresses, STATUS layout, done-flag states
// Revision 1.0
// ==================================================================
`timescale 1ns/1ps
`default_nettype none

package mmio_console_pkg;

    localparam logic [31:0] MMIO_PRINT_ADDR  = 32'h1000_0000;
    localparam logic [31:0] MMIO_DONE_ADDR   = 32'h1000_0004;
    localparam logic [31:0] MMIO_STATUS_ADDR = 32'h1000_0008;

    localparam int STATUS_COUNT_LSB = 0;
    localparam int STATUS_FULL_BIT  = 8;
    localparam int STATUS_EMPTY_BIT = 9;
    localparam int STATUS_DONE_BIT  = 10;
    localparam int STATUS_DROP_LSB  = 16;

    typedef enum logic {
        DONE_IDLE = 1'b0,
        DONE_SET  = 1'b1
    } done_state_e;

    function automatic logic [31:0] status_word(
        input logic [7:0]  count,
        input logic        full,
        input logic        empty,
        input logic        done,
        input logic [15:0] drop
    );
        logic [31:0] w;
        w = '0;
        w[STATUS_COUNT_LSB +: 8] = count;
        w[STATUS_FULL_BIT]       = full;
        w[STATUS_EMPTY_BIT]      = empty;
        w[STATUS_DONE_BIT]       = done;
        w[STATUS_DROP_LSB +: 16] = drop;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_console_if.sv
// ==================================================================
// mmio_console_if : CPU data-bus slice plus the console output stream
// Revision 1.0
// ==================================================================
`timescale 1ns/1ps
`default_nettype none

interface mmio_console_if;
    logic [31:0] memory_address;
    logic        memory_write_enable;
    logic [31:0] memory_write_data;
    logic        memory_read_enable;
    logic        mmio_hit;
    logic [31:0] mmio_read_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    modport master (
        output memory_address, memory_write_enable, memory_write_data,
               memory_read_enable, out_ready,
        input  mmio_hit, mmio_read_data, out_valid, out_data
    );

    modport slave (
        input  memory_address, memory_write_enable, memory_write_data,
               memory_read_enable, out_ready,
        output mmio_hit, mmio_read_data, out_valid, out_data
    );
endinterface

`default_nettype wire

// File: rtl/mmio_console_sync_fifo.sv
// ==================================================================
// sync_fifo : single-clock FIFO, head word presented combinationally
// Revision 1.0
// ==================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  wire logic             clk,
    input  wire logic             n_rst,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic             pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CW-1:0]         count_o,
    output logic [WIDTH-1:0]      head_o
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o    = (count_q == FULL_COUNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);
    // Head reads as zero when empty so the stream data is clean after reset.
    assign head_o    = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mmio_console.sv
// ==================================================================
// mmio_console : PRINT FIFO, sticky DONE/exit code, STATUS readback
// Revision 1.0
// ==================================================================
`timescale 1ns/1ps
`default_nettype none

module mmio_console
    import mmio_console_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  wire logic    clk,
    input  wire logic    n_rst,
    mmio_console_if.slave bus,
    output logic         done,
    output logic [31:0]  exit_code
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic              w_hit_print;
    logic              w_hit_done;
    logic              w_hit_status;
    logic              w_push_req;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [31:0]       w_status;
    logic [DROP_W-1:0] drop_q;
    done_state_e       state_q;
    done_state_e       state_d;
    logic [31:0]       exit_code_q;
    logic [31:0]       exit_code_d;

    assign w_hit_print  = (bus.memory_address == MMIO_PRINT_ADDR);
    assign w_hit_done   = (bus.memory_address == MMIO_DONE_ADDR);
    assign w_hit_status = (bus.memory_address == MMIO_STATUS_ADDR);
    assign bus.mmio_hit = w_hit_print || w_hit_done || w_hit_status;

    // A full FIFO still takes a store when the head leaves on the same edge.
    assign w_push_req = bus.memory_write_enable && w_hit_print;
    assign w_pop      = bus.out_valid && bus.out_ready;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .push_i  (w_push),
        .data_i  (bus.memory_write_data),
        .pop_i   (w_pop),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count),
        .head_o  (bus.out_data)
    );

    assign bus.out_valid = !w_empty;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            drop_q <= '0;
        end else if (w_drop && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= DONE_IDLE;
            exit_code_q <= '0;
        end else begin
            state_q     <= state_d;
            exit_code_q <= exit_code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        exit_code_d = exit_code_q;
        case (state_q)
            DONE_IDLE: begin
                if (bus.memory_write_enable && w_hit_done) begin
                    state_d     = DONE_SET;
                    exit_code_d = bus.memory_write_data;
                end
            end
            DONE_SET: begin
                state_d = DONE_SET;
            end
            default: begin
                state_d = DONE_IDLE;
            end
        endcase
    end

    assign done      = (state_q == DONE_SET);
    assign exit_code = exit_code_q;

    assign w_status = status_word(8'(w_count), w_full, w_empty, done, 16'(drop_q));
    assign bus.mmio_read_data = (bus.memory_read_enable && w_hit_status) ? w_status : '0;

endmodule

`default_nettype wire
